// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV32I fields into a 32-bit word for imem.
// One valid/ready stage; sequential word address; immediate range check.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   field-bundle handshake
//   fmt                 0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   opcode, rd, rs1,
//   rs2, funct3,
//   funct7, imm         decoded instruction fields
//   addr_load, addr_in  write-pointer load
//   out_valid/out_ready output handshake
//   out_inst, out_addr  encoded word and its imem word address
//   out_err             immediate not encodable or fmt illegal
//   err_cnt             saturating count of accepted bad bundles
module inst_encoder #(
  parameter int IMEM_AW    = 9,
  parameter int START_ADDR = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         fmt,
  input  logic [6:0]         opcode,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic [31:0]        imm,
  input  logic               addr_load,
  input  logic [IMEM_AW-1:0] addr_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_inst,
  output logic [IMEM_AW-1:0] out_addr,
  output logic               out_err,
  output logic [7:0]         err_cnt
);

  localparam logic [2:0] F_R = 3'd0;
  localparam logic [2:0] F_I = 3'd1;
  localparam logic [2:0] F_S = 3'd2;
  localparam logic [2:0] F_B = 3'd3;
  localparam logic [2:0] F_U = 3'd4;
  localparam logic [2:0] F_J = 3'd5;

  localparam logic [6:0] OP_IMM = 7'b0010011;

  logic [IMEM_AW-1:0] ptr;
  logic [IMEM_AW-1:0] base;
  logic [31:0]        enc;
  logic               bad;
  logic               accept;
  logic               is_shift;
  logic               sx11;
  logic               sx12;
  logic               sx20;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A coinciding load redirects the accepted word itself.
  assign base = addr_load ? addr_in : ptr;

  // Shift-immediates carry funct7 above a 5-bit shamt.
  assign is_shift = (fmt == F_I) && (opcode == OP_IMM)
                 && (funct3 == 3'b001 || funct3 == 3'b101);

  // Upper bits must be copies of the format's sign bit.
  assign sx11 = (imm[31:11] == {21{imm[11]}});
  assign sx12 = (imm[31:12] == {20{imm[12]}});
  assign sx20 = (imm[31:20] == {12{imm[20]}});

  always_comb begin
    enc = '0;
    bad = 1'b0;
    unique case (1'b1)
      (fmt == F_R): begin
        enc = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      is_shift: begin
        enc = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        bad = (imm[31:5] != '0);
      end
      (fmt == F_I) && !is_shift: begin
        enc = {imm[11:0], rs1, funct3, rd, opcode};
        bad = !sx11;
      end
      (fmt == F_S): begin
        enc = {imm[11:5], rs2, rs1, funct3,
               imm[4:0], opcode};
        bad = !sx11;
      end
      (fmt == F_B): begin
        enc = {imm[12], imm[10:5], rs2, rs1, funct3,
               imm[4:1], imm[11], opcode};
        bad = !sx12 || imm[0];
      end
      (fmt == F_U): begin
        enc = {imm[31:12], rd, opcode};
        bad = (imm[11:0] != '0);
      end
      (fmt == F_J): begin
        enc = {imm[20], imm[10:1], imm[11],
               imm[19:12], rd, opcode};
        bad = !sx20 || imm[0];
      end
      default: begin
        enc = '0;
        bad = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_addr  <= '0;
      out_err   <= 1'b0;
      err_cnt   <= '0;
      ptr       <= IMEM_AW'(START_ADDR);
    end else if (accept) begin
      out_valid <= 1'b1;
      out_inst  <= enc;
      out_addr  <= base;
      out_err   <= bad;
      ptr       <= base + IMEM_AW'(1);
      if (bad && err_cnt != 8'hff)
        err_cnt <= err_cnt + 8'd1;
    end else begin
      if (out_ready)
        out_valid <= 1'b0;
      if (addr_load)
        ptr <= addr_in;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed stream with a scoreboard queue.
// Expected words pushed on accept, popped on output transfer.
module tb_inst_encoder;

  localparam int AW = 9;

  typedef struct packed {
    logic [31:0]   inst;
    logic [AW-1:0] addr;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    fmt;
  logic [6:0]    opcode;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [31:0]   imm;
  logic          addr_load;
  logic [AW-1:0] addr_in;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic [AW-1:0] out_addr;
  logic          out_err;
  logic [7:0]    err_cnt;

  exp_t          sb[$];
  logic [AW-1:0] mptr;
  logic [AW-1:0] last_addr;
  logic [31:0]   exp_inst;
  logic          exp_err;
  int            ntest = 0;
  int            nfail = 0;

  always #5 clk = ~clk;

  inst_encoder #(.IMEM_AW(AW), .START_ADDR(0)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd),
    .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm),
    .addr_load(addr_load), .addr_in(addr_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr),
    .out_err(out_err), .err_cnt(err_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Sample just before the edge, then step past it.
  task automatic cyc(output bit acc);
    exp_t    e;
    logic [AW-1:0] a;
    #1;
    acc = 1'b0;
    if (!reset) begin
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_inst", out_inst, e.inst);
          chk("sb_addr", 32'(out_addr), 32'(e.addr));
          chk("sb_err", 32'(out_err), 32'(e.err));
        end
      end
      if (in_valid && in_ready) begin
        acc = 1'b1;
        a = addr_load ? addr_in : mptr;
        sb.push_back('{exp_inst, a, exp_err});
        last_addr = a;
        mptr = a + AW'(1);
      end else if (addr_load) begin
        mptr = addr_in;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f,
                       input logic [6:0] op,
                       input logic [4:0] d,
                       input logic [4:0] s1,
                       input logic [4:0] s2,
                       input logic [2:0] f3,
                       input logic [6:0] f7,
                       input logic [31:0] im,
                       input logic [31:0] ei,
                       input logic ee);
    fmt = f; opcode = op; rd = d;
    rs1 = s1; rs2 = s2; funct3 = f3;
    funct7 = f7; imm = im;
    exp_inst = ei; exp_err = ee;
  endtask

  task automatic send();
    bit acc;
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      cyc(acc);
      done = acc;
    end
    in_valid = 1'b0;
    chk("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic idle();
    bit acc;
    in_valid = 1'b0;
    cyc(acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    addr_load = 1'b0; addr_in = '0;
    drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0,
          32'd0, 32'd0, 1'b0);
    mptr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_addr", 32'(out_addr), 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_cnt", 32'(err_cnt), 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);

    // addi x1,x0,5
    drive(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0,
          7'd0, 32'd5, 32'h00500093, 1'b0);
    send();
    chk("addi_inst", out_inst, 32'h00500093);
    chk("addi_addr", 32'(out_addr), 32'd0);
    // sw x2,8(x1)
    drive(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010,
          7'd0, 32'd8, 32'h0020A423, 1'b0);
    send();
    // beq x0,x0,-4
    drive(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0,
          7'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
    send();
    // jal x1,8
    drive(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0,
          7'd0, 32'd8, 32'h008000EF, 1'b0);
    send();
    // srai x3,x3,4
    drive(3'd1, 7'b0010011, 5'd3, 5'd3, 5'd0, 3'b101,
          7'b0100000, 32'd4, 32'h4041D193, 1'b0);
    send();
    chk("srai_addr", 32'(out_addr), 32'd4);
    // add x3,x1,x2 with junk imm
    drive(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0,
          7'd0, 32'hFFFFFFFF, 32'h002081B3, 1'b0);
    send();
    // lui x5,0x12345
    drive(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0,
          7'd0, 32'h12345000, 32'h123452B7, 1'b0);
    send();
    // addi x1,x0,-1
    drive(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0,
          7'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
    send();
    chk("cnt_clean", 32'(err_cnt), 32'd0);

    // error cases
    drive(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0,
          7'd0, 32'd3, 32'h00000163, 1'b1);
    send();
    chk("b_odd_err", 32'(out_err), 32'd1);
    chk("cnt_1", 32'(err_cnt), 32'd1);
    drive(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0,
          7'd0, 32'h800, 32'h80000093, 1'b1);
    send();
    chk("cnt_2", 32'(err_cnt), 32'd2);
    drive(3'd6, 7'b0010011, 5'd1, 5'd1, 5'd1, 3'd0,
          7'd0, 32'd0, 32'h0, 1'b1);
    send();
    chk("fmt6_inst", out_inst, 32'd0);
    chk("fmt6_err", 32'(out_err), 32'd1);
    drive(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0,
          7'd0, 32'h12345678, 32'h123452B7, 1'b1);
    send();
    drive(3'd1, 7'b0010011, 5'd3, 5'd3, 5'd0, 3'b101,
          7'd0, 32'd32, 32'h0001D193, 1'b1);
    send();
    drive(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0,
          7'd0, 32'd5, 32'h004000EF, 1'b1);
    send();
    chk("cnt_6", 32'(err_cnt), 32'd6);
    for (int i = 0; i < 300; i++) begin
      drive(3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 3'd7,
            7'h7F, 32'hFFFFFFFF, 32'h0, 1'b1);
      send();
    end
    chk("cnt_sat", 32'(err_cnt), 32'd255);

    // backpressure
    idle();
    out_ready = 1'b0;
    drive(3'd1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0,
          7'd0, 32'd7, 32'h00700113, 1'b0);
    send();
    drive(3'd1, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0,
          7'd0, 32'd9, 32'h00900193, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_inst", out_inst, 32'h00700113);
      chk("bp_addr", 32'(out_addr), 32'(last_addr));
      cyc(acc);
    end
    out_ready = 1'b1;
    send();
    chk("bp_next", out_inst, 32'h00900193);

    // pointer wrap and load
    addr_load = 1'b1; addr_in = 9'd511;
    idle();
    addr_load = 1'b0;
    drive(3'd0, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0,
          7'd0, 32'd0, 32'h003100B3, 1'b0);
    send();
    chk("ptr_511", 32'(out_addr), 32'd511);
    send();
    chk("ptr_wrap", 32'(out_addr), 32'd0);
    addr_load = 1'b1; addr_in = 9'd20;
    send();
    addr_load = 1'b0;
    chk("ptr_load", 32'(out_addr), 32'd20);
    send();
    chk("ptr_21", 32'(out_addr), 32'd21);

    // reset with a held word
    idle();
    out_ready = 1'b0;
    send();
    reset = 1'b1;
    cyc(acc);
    sb.delete();
    mptr = '0;
    reset = 1'b0;
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_cnt", 32'(err_cnt), 32'd0);
    out_ready = 1'b1;
    send();
    chk("mid_addr", 32'(out_addr), 32'd0);
    for (int i = 0; i < 10 && sb.size() != 0; i++)
      idle();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             ntest, nfail);
    $finish;
  end

endmodule
